key_debounce: RTL

- Conditions the raw DE1 push-buttons ahead of the memory-mapped I/O layer.
- Per key: synchronises the raw input, debounces it, and emits a single-cycle press pulse.
- KEY_PULSE drives the I/O layer's KEY[2:0] set/reset register directly, so each physical press produces exactly one set event.
- Also exports the debounced level for LED/debug use.

---
 rtl/key_debounce.sv | 130 +++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// key_debounce: per-key 2-flop synchroniser, debounce FSM and press pulse
// generator for the active-low DE1 push-buttons. KEY_PULSE feeds the I/O
// layer's key set/reset register (one set event per physical press);
// KEY_LEVEL is the debounced held state for LEDs/debug.
module key_debounce #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] KEY_n,
  output logic [NUM_KEYS-1:0] KEY_PULSE,
  output logic [NUM_KEYS-1:0] KEY_LEVEL
);

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  // Count reaching CNT_LAST on a still-stable sample completes the window.
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1_r;
  logic [NUM_KEYS-1:0] sync2_r;

  // Two-flop synchroniser; both stages reset to the released (high) level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= {NUM_KEYS{1'b1}};
      sync2_r <= {NUM_KEYS{1'b1}};
    end else begin
      sync1_r <= KEY_n;
      sync2_r <= sync1_r;
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             pressed_s;
    logic             accept_s;
    logic             armed_r;
    logic             pulse_r;
    logic             level_r;

    assign pressed_s = ~sync2_r[k];

    // Next-state and counter logic; accept_s marks the PRESS_WAIT->PRESSED step.
    always_comb begin
      state_s  = state_r;
      cnt_s    = CNT_ZERO;
      accept_s = 1'b0;
      case (state_r)
        ST_RELEASED: begin
          if (pressed_s) begin
            cnt_s   = CNT_ONE;
            state_s = ST_PRESS_WAIT;
          end else begin
            cnt_s   = CNT_ZERO;
          end
        end
        ST_PRESS_WAIT: begin
          if (!pressed_s) begin
            cnt_s   = CNT_ZERO;
            state_s = ST_RELEASED;
          end else if (cnt_r == CNT_LAST) begin
            cnt_s    = CNT_ZERO;
            state_s  = ST_PRESSED;
            accept_s = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!pressed_s) begin
            cnt_s   = CNT_ONE;
            state_s = ST_RELEASE_WAIT;
          end else begin
            cnt_s   = CNT_ZERO;
          end
        end
        ST_RELEASE_WAIT: begin
          if (pressed_s) begin
            cnt_s   = CNT_ZERO;
            state_s = ST_PRESSED;
          end else if (cnt_r == CNT_LAST) begin
            cnt_s   = CNT_ZERO;
            state_s = ST_RELEASED;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          cnt_s   = CNT_ZERO;
          state_s = ST_RELEASED;
        end
      endcase
    end

    // State/counter register plus registered outputs; the pulse is delayed
    // through armed_r so it lines up with the first cycle KEY_LEVEL is high.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_r <= ST_RELEASED;
        cnt_r   <= CNT_ZERO;
        armed_r <= 1'b0;
        pulse_r <= 1'b0;
        level_r <= 1'b0;
      end else begin
        state_r <= state_s;
        cnt_r   <= cnt_s;
        armed_r <= accept_s;
        pulse_r <= armed_r;
        level_r <= (state_r == ST_PRESSED) || (state_r == ST_RELEASE_WAIT);
      end
    end

    assign KEY_PULSE[k] = pulse_r;
    assign KEY_LEVEL[k] = level_r;
  end

endmodule
